glb_stream_sink: RTL and testbench

Synthesizable receive endpoint for the 17-bit sparse ready/valid stream emitted by `reduce_pe_cluster` (`res`/`res_valid`/`res_ready`). It is the on-chip counterpart of the stream driver: it applies backpressure, buffers accepted words in a FIFO for a downstream reader, classifies tokens, and measures stream latency. It is used as a GLB-side sink in cluster-level harnesses and on-FPGA bring-up.

---
 rtl/glb_stream_pkg.sv | 33 +++
 rtl/glb_stream_sink_fifo.sv | 77 +++++++
 rtl/glb_stream_sink.sv | 171 +++++++++++++++++
 tb/tb_glb_stream_sink.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_stream_pkg.sv
// glb_stream_pkg: shared constants, state encoding and token helpers for the
// GLB-side stream sink (17-bit sparse ready/valid stream).
package glb_stream_pkg;

    localparam int DATA_W    = 17;
    localparam int TOKEN_BIT = 16;

    localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_e;

    // STOP token: token bit set and an all-zero upper data byte (level in [7:0]).
    function automatic logic is_stop(input logic [DATA_W-1:0] word);
        return word[TOKEN_BIT] & (word[15:8] == 8'h00);
    endfunction

    // Any token that is neither DONE nor STOP is malformed.
    function automatic logic is_bad_token(input logic [DATA_W-1:0] word);
        return word[TOKEN_BIT] & (word != DONE_TOKEN) & ~is_stop(word);
    endfunction

    // One step of the 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/glb_stream_sink_fifo.sv
// glb_stream_sink_fifo: first-word fall-through FIFO with extra-MSB pointers.
// Full when pointer MSBs differ and the index bits match; empty when equal.
module glb_stream_sink_fifo
    import glb_stream_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A flush cycle neither stores nor retires anything.
    assign push_ok_s = push & ~full & ~flush;
    assign pop_ok_s  = pop & ~empty & ~flush;

    // Head is presented while non-empty; an empty FIFO shows zero.
    assign rd_data = empty ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state: advance on accepted push/pop, wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers with async reset and synchronous flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/glb_stream_sink.sv
// glb_stream_sink: receive endpoint for the reduce_pe_cluster result stream.
// Buffers accepted words in a FWFT FIFO, classifies tokens, counts words and
// STOP tokens, and measures cycles from first valid to DONE acceptance.
// Optional pseudo-random backpressure: define GLB_STREAM_SINK_RAND_STALL_EN.
module glb_stream_sink
    import glb_stream_pkg::*;
#(
    parameter int          DEPTH = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic [63:0]       cycle_count,
    output logic [15:0]       word_count,
    output logic [15:0]       stop_count,
    output logic              bad_token
);

    sink_state_e state_q;
    sink_state_e state_d;
    logic [63:0] cycle_q;
    logic [63:0] cycle_d;
    logic [15:0] word_cnt_q;
    logic [15:0] word_cnt_d;
    logic [15:0] stop_cnt_q;
    logic [15:0] stop_cnt_d;
    logic        bad_q;
    logic        bad_d;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        lfsr_stall_s;
    logic        ready_s;
    logic        accept_s;
    logic        accept_done_s;

`ifdef GLB_STREAM_SINK_RAND_STALL_EN
    logic [15:0] lfsr_q;

    // Backpressure LFSR: free-running outside reset and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (flush) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_stall_s = lfsr_q[0];
`else
    assign lfsr_stall_s = 1'b0;
`endif

    // ready is derived from registered state only; no path from valid.
    assign ready_s       = ~fifo_full_s & (state_q != DONE) & ~lfsr_stall_s;
    assign accept_s      = valid & ready_s & ~flush;
    assign accept_done_s = accept_s & (data == DONE_TOKEN);

    glb_stream_sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (accept_s),
        .push_data (data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // FSM next-state plus latency counter; the first-valid cycle is counted
    // so that the total spans first valid through DONE acceptance inclusive.
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    cycle_d = cycle_q + 64'd1;
                    if (accept_done_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cycle_d = cycle_q + 64'd1;
                if (accept_done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating word/STOP counters and sticky malformed-token flag.
    always_comb begin
        word_cnt_d = word_cnt_q;
        stop_cnt_d = stop_cnt_q;
        bad_d      = bad_q;
        if (accept_s && !data[TOKEN_BIT] && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
        if (accept_s && is_stop(data) && (stop_cnt_q != 16'hFFFF)) begin
            stop_cnt_d = stop_cnt_q + 16'd1;
        end else begin
            stop_cnt_d = stop_cnt_q;
        end
        if (accept_s && is_bad_token(data)) begin
            bad_d = 1'b1;
        end else begin
            bad_d = bad_q;
        end
    end

    // Control and status registers; flush wins over every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cycle_q    <= 64'd0;
            word_cnt_q <= 16'd0;
            stop_cnt_q <= 16'd0;
            bad_q      <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            cycle_q    <= 64'd0;
            word_cnt_q <= 16'd0;
            stop_cnt_q <= 16'd0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            word_cnt_q <= word_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            bad_q      <= bad_d;
        end
    end

    assign ready       = ready_s;
    assign rd_valid    = ~fifo_empty_s;
    assign done        = (state_q == DONE);
    assign cycle_count = cycle_q;
    assign word_count  = word_cnt_q;
    assign stop_count  = stop_cnt_q;
    assign bad_token   = bad_q;

endmodule

// File: tb/tb_glb_stream_sink.sv
// Directed self-checking bench for glb_stream_sink (DEPTH=4).
module tb_glb_stream_sink;
    import glb_stream_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [16:0] data;
    logic        valid;
    logic        ready;
    logic        rd_en;
    logic [16:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic [63:0] cycle_count;
    logic [15:0] word_count;
    logic [15:0] stop_count;
    logic        bad_token;

    int n_cmp = 0;
    int n_err = 0;

    glb_stream_sink #(
        .DEPTH (DEPTH),
        .SEED  (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .cycle_count (cycle_count),
        .word_count  (word_count),
        .stop_count  (stop_count),
        .bad_token   (bad_token)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

`ifdef GLB_STREAM_SINK_RAND_STALL_EN
    logic [16:0] ws [21];
    logic [15:0] m;
    logic        mdone;
    logic        last_acc;
    logic        exp_rdy;
    logic        fb;
    int          acc_idx;
    int          pop_idx;
    int          cyc;
    logic [63:0] exp_cc;

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rd_en = 1'b0; data = 17'h0;
        for (int i = 0; i < 20; i++) ws[i] = 17'(17'h00001 + 3 * i);
        ws[20] = DONE_TOKEN;
        tick(); tick();
        chk("rst_ready", ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_cycle", cycle_count, 64'd0);
        rst_n = 1'b1;
        m = SEED; mdone = 1'b0; last_acc = 1'b0;
        acc_idx = 0; pop_idx = 0; cyc = 0; exp_cc = 64'd0;
        valid = 1'b1; rd_en = 1'b1;
        while (!mdone && cyc < 600) begin
            exp_rdy = ~m[0] & ~mdone;
            data = ws[acc_idx];
            chk("stall_ready", ready, exp_rdy);
            chk("stall_rd_valid", rd_valid, last_acc);
            if (last_acc) begin
                chk("stall_order", rd_data, ws[pop_idx]);
                pop_idx++;
            end
            tick();
            exp_cc = exp_cc + 64'd1;
            last_acc = exp_rdy;
            if (exp_rdy) begin
                if (acc_idx == 20) mdone = 1'b1;
                acc_idx++;
            end
            fb = m[0] ^ m[2] ^ m[3] ^ m[5];
            m = {fb, m[15:1]};
            cyc++;
        end
        valid = 1'b0;
        chk("stall_done_reached", mdone, 1'b1);
        chk("stall_done", done, 1'b1);
        chk("stall_cycle", cycle_count, exp_cc);
        chk("stall_words", word_count, 16'd20);
        chk("stall_ready_after", ready, 1'b0);
        chk("stall_last_valid", rd_valid, 1'b1);
        chk("stall_last_word", rd_data, DONE_TOKEN);
        tick();
        rd_en = 1'b0;
        chk("stall_drained", rd_valid, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
`else
    logic [16:0] t1 [4];
    logic [16:0] w2 [6];
    logic [16:0] w3;

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rd_en = 1'b0; data = 17'h0;
        t1[0] = 17'h00005; t1[1] = 17'h00007; t1[2] = 17'h10000; t1[3] = 17'h10100;
        for (int i = 0; i < 6; i++) w2[i] = 17'(17'h00A00 + i);
        tick(); tick();
        // reset values
        chk("rst_ready", ready, 1'b1);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 17'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_bad", bad_token, 1'b0);
        chk("rst_cycle", cycle_count, 64'd0);
        chk("rst_words", word_count, 16'd0);
        chk("rst_stops", stop_count, 16'd0);
        rst_n = 1'b1;
        tick();

        // basic stream: 4 transfers in 4 cycles
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = t1[i];
            chk("t1_ready", ready, 1'b1);
            tick();
        end
        valid = 1'b0; data = 17'h0;
        chk("t1_words", word_count, 16'd2);
        chk("t1_stops", stop_count, 16'd1);
        chk("t1_done", done, 1'b1);
        chk("t1_cycle", cycle_count, 64'd4);
        chk("t1_ready_after", ready, 1'b0);
        chk("t1_bad", bad_token, 1'b0);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_drain", rd_data, t1[i]);
            tick();
        end
        rd_en = 1'b0;
        chk("t1_empty", rd_valid, 1'b0);
        chk("t1_cycle_hold", cycle_count, 64'd4);

        // full FIFO backpressure
        do_flush();
        chk("fl_done", done, 1'b0);
        chk("fl_ready", ready, 1'b1);
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = w2[i];
            tick();
        end
        chk("t2_ready_full", ready, 1'b0);
        chk("t2_words4", word_count, 16'd4);
        chk("t2_head0", rd_data, w2[0]);
        data = w2[4];
        tick();
        chk("t2_no_accept", word_count, 16'd4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t2_head1", rd_data, w2[1]);
        chk("t2_ready_back", ready, 1'b1);
        chk("t2_no_push_on_full_pop", word_count, 16'd4);
        tick();
        valid = 1'b0;
        chk("t2_words5", word_count, 16'd5);
        chk("t2_ready_full2", ready, 1'b0);
        rd_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("t2_drain", rd_data, w2[i]);
            tick();
        end
        rd_en = 1'b0;
        chk("t2_empty", rd_valid, 1'b0);

        // simultaneous push/pop across pointer wraparound
        do_flush();
        valid = 1'b1; data = 17'h00100;
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            w3 = 17'(17'h00100 + i);
            data = 17'(17'h00101 + i);
            chk("t3_valid", rd_valid, 1'b1);
            chk("t3_order", rd_data, w3);
            chk("t3_ready", ready, 1'b1);
            tick();
        end
        valid = 1'b0;
        chk("t3_last", rd_data, 17'h0010C);
        tick();
        rd_en = 1'b0;
        chk("t3_empty", rd_valid, 1'b0);
        chk("t3_words", word_count, 16'd13);

        // pop on empty ignored; malformed and STOP tokens
        do_flush();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t4_empty_pop", rd_valid, 1'b0);
        chk("t4_empty_data", rd_data, 17'h0);
        valid = 1'b1; data = 17'h10205;
        tick();
        chk("t4_bad", bad_token, 1'b1);
        chk("t4_stop0", stop_count, 16'd0);
        chk("t4_pushed", rd_data, 17'h10205);
        data = 17'h10003;
        tick();
        valid = 1'b0;
        chk("t4_stop1", stop_count, 16'd1);
        chk("t4_bad_sticky", bad_token, 1'b1);
        chk("t4_words", word_count, 16'd0);
        rd_en = 1'b1;
        tick();
        chk("t4_second", rd_data, 17'h10003);
        tick();
        rd_en = 1'b0;
        chk("t4_drained", rd_valid, 1'b0);

        // flush mid-stream after 3 accepts, then restart
        do_flush();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = 17'(17'h00050 + i);
            tick();
        end
        chk("t5_words3", word_count, 16'd3);
        chk("t5_cycle3", cycle_count, 64'd3);
        data = 17'h00053; flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        chk("t5_words0", word_count, 16'd0);
        chk("t5_stops0", stop_count, 16'd0);
        chk("t5_cycle0", cycle_count, 64'd0);
        chk("t5_rd_valid", rd_valid, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_ready", ready, 1'b1);
        tick();
        chk("t5_idle_hold", cycle_count, 64'd0);
        valid = 1'b1; data = 17'h00005;
        tick();
        data = DONE_TOKEN;
        tick();
        valid = 1'b0;
        chk("t5_restart_words", word_count, 16'd1);
        chk("t5_restart_cycle", cycle_count, 64'd2);
        chk("t5_restart_done", done, 1'b1);
        chk("t5_restart_head", rd_data, 17'h00005);

        // asynchronous reset clears immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_done", done, 1'b0);
        chk("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_words", word_count, 16'd0);
        tick();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
`endif

endmodule
